// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB types and protection-attribute constants
//
// Purpose: common definitions for blocks on the APB segment.
// Contents:
//   prot_t       - 3-bit APB protection attribute (pprot)
//   PROT_DEFAULT - normal, secure, data access
//   PROT_PRIV    - privileged, secure, data access
package apb_pkg;

  typedef logic [2:0] prot_t;

  localparam prot_t PROT_DEFAULT = 3'b000;
  localparam prot_t PROT_PRIV    = 3'b001;

endpackage : apb_pkg

// File: rtl/apb_req_master.sv
// rtl/apb_req_master.sv - valid/ready request channel to single APB transfers with wait-state timeout
//
// Purpose: initiator end of the APB segment. Accepts one request at a time,
// runs it as an APB SETUP/ACCESS transfer, and returns the completion on a
// valid/ready response channel. A bounded ACCESS wait counter terminates
// transfers to a hung or absent slave.
// Ports:
//   clk_i, rst_ni                    clock, asynchronous active-low reset
//   req_valid_i / req_ready_o        request handshake
//   req_addr_i, req_write_i, req_wdata_i, req_strb_i, req_prot_i
//                                    request fields
//   rsp_valid_o / rsp_ready_i        response handshake
//   rsp_rdata_o, rsp_err_o, rsp_timeout_o
//                                    response fields
//   paddr_o, pprot_o, pwrite_o, pwdata_o, pstrb_o, psel_o, penable_o
//                                    APB request side
//   pready_i, prdata_i, pslverr_i    APB completion side
module apb_req_master
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,

  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic                  req_write_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [STRB_WIDTH-1:0] req_strb_i,
  input  logic [2:0]            req_prot_i,

  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  rsp_timeout_o,

  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic [2:0]            pprot_o,
  output logic                  pwrite_o,
  output logic [DATA_WIDTH-1:0] pwdata_o,
  output logic [STRB_WIDTH-1:0] pstrb_o,
  output logic                  psel_o,
  output logic                  penable_o,
  input  logic                  pready_i,
  input  logic [DATA_WIDTH-1:0] prdata_i,
  input  logic                  pslverr_i
);

  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam int WCNT_WIDTH = TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WCNT_WIDTH-1:0] WCNT_LAST =
    TIMEOUT_EN ? WCNT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  state_t state_q, state_d;

  // ready is registered so it reads 0 while reset is held and only rises
  // on the first clock in IDLE; it is 1 exactly when state_q is IDLE
  // after that first clock.
  logic ready_q;
  logic accept;
  logic timeout_hit;

  logic [WCNT_WIDTH-1:0] wcnt_q;

  logic [ADDR_WIDTH-1:0] paddr_q;
  prot_t                 pprot_q;
  logic                  pwrite_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic [STRB_WIDTH-1:0] pstrb_q;

  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic                  timeout_q;

  assign accept = ready_q && req_valid_i;

  always_comb begin
    state_d     = state_q;
    timeout_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = SETUP;
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        // pready wins over a coinciding timeout
        if (pready_i) begin
          state_d = RESP;
        end else if (TIMEOUT_EN && (wcnt_q == WCNT_LAST)) begin
          state_d     = RESP;
          timeout_hit = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == IDLE);
    end
  end

  // Request fields change only on acceptance and hold their value afterwards.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      paddr_q  <= '0;
      pprot_q  <= PROT_DEFAULT;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
    end else if (accept) begin
      paddr_q  <= req_addr_i;
      pprot_q  <= req_prot_i;
      pwrite_q <= req_write_i;
      pwdata_q <= req_wdata_i;
      pstrb_q  <= req_write_i ? req_strb_i : '0;
    end
  end

  // Wait counter: cleared in SETUP so it reads 0 in the first ACCESS cycle,
  // then counts ACCESS cycles without pready and saturates.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wcnt_q <= '0;
    end else if (state_q == SETUP) begin
      wcnt_q <= '0;
    end else if ((state_q == ACCESS) && !pready_i && (wcnt_q != '1)) begin
      wcnt_q <= wcnt_q + 1'b1;
    end
  end

  // Completion capture happens only in ACCESS, so the APB completion inputs
  // are ignored in every other state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q   <= '0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else if (state_q == ACCESS) begin
      if (pready_i) begin
        rdata_q   <= pwrite_q ? '0 : prdata_i;
        err_q     <= pslverr_i;
        timeout_q <= 1'b0;
      end else if (timeout_hit) begin
        rdata_q   <= '0;
        err_q     <= 1'b1;
        timeout_q <= 1'b1;
      end
    end
  end

  assign req_ready_o   = ready_q;
  assign psel_o        = (state_q == SETUP) || (state_q == ACCESS);
  assign penable_o     = (state_q == ACCESS);
  assign rsp_valid_o   = (state_q == RESP);
  assign rsp_rdata_o   = rdata_q;
  assign rsp_err_o     = err_q;
  assign rsp_timeout_o = timeout_q;
  assign paddr_o       = paddr_q;
  assign pprot_o       = pprot_q;
  assign pwrite_o      = pwrite_q;
  assign pwdata_o      = pwdata_q;
  assign pstrb_o       = pstrb_q;

endmodule : apb_req_master

// File: tb/tb_apb_req_master.sv
// tb/tb_apb_req_master.sv - self-checking bench for apb_req_master
module tb_apb_req_master;
  import apb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          req_write;
  logic [DW-1:0] req_wdata;
  logic [SW-1:0] req_strb;
  logic [2:0]    req_prot;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic [AW-1:0] paddr;
  logic [2:0]    pprot;
  logic          pwrite;
  logic [DW-1:0] pwdata;
  logic [SW-1:0] pstrb;
  logic          psel;
  logic          penable;
  logic          pready;
  logic [DW-1:0] prdata;
  logic          pslverr;

  always #5 clk = ~clk;

  apb_req_master #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_addr_i   (req_addr),
    .req_write_i  (req_write),
    .req_wdata_i  (req_wdata),
    .req_strb_i   (req_strb),
    .req_prot_i   (req_prot),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_err_o    (rsp_err),
    .rsp_timeout_o(rsp_timeout),
    .paddr_o      (paddr),
    .pprot_o      (pprot),
    .pwrite_o     (pwrite),
    .pwdata_o     (pwdata),
    .pstrb_o      (pstrb),
    .psel_o       (psel),
    .penable_o    (penable),
    .pready_i     (pready),
    .prdata_i     (prdata),
    .pslverr_i    (pslverr)
  );

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    prot_t         prot;
    int            waits;
    logic          slverr;
    logic [DW-1:0] prdata;
    int            hold;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
    logic          exp_to;
    int            exp_acc;
    logic [SW-1:0] exp_strb;
  } vec_t;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    logic          to;
  } rsp_t;

  rsp_t sb_q[$];
  vec_t vecs[8];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] s, input prot_t p, input int wt,
                              input logic se, input logic [31:0] rd, input int h,
                              input logic [31:0] erd, input logic eerr, input logic eto,
                              input int eacc, input logic [3:0] estrb);
    vec_t v;
    v.write = w; v.addr = a; v.wdata = wd; v.strb = s; v.prot = p; v.waits = wt;
    v.slverr = se; v.prdata = rd; v.hold = h; v.exp_rdata = erd; v.exp_err = eerr;
    v.exp_to = eto; v.exp_acc = eacc; v.exp_strb = estrb;
    return v;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_txn(input vec_t v);
    int   cyc, acc, sel, lat;
    bit   seen;
    rsp_t e, got, held;
    req_valid = 1'b1; req_addr = v.addr; req_write = v.write; req_wdata = v.wdata;
    req_strb = v.strb; req_prot = v.prot;
    cyc = 0;
    while (req_ready !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("accept_in_time", 64'(cyc < 20), 64'd1);
    e.rdata = v.exp_rdata; e.err = v.exp_err; e.to = v.exp_to;
    sb_q.push_back(e);
    @(negedge clk);
    // Scramble request inputs: the APB fields must hold the accepted values.
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    req_strb = 4'($urandom); req_write = ~v.write; req_prot = 3'($urandom);
    acc = 0; sel = 0; lat = 1; seen = 0;
    while (!seen && lat < 40) begin
      if (rsp_valid === 1'b1) begin
        seen = 1;
      end else begin
        if (psel === 1'b1) begin
          sel++;
          chk("paddr", 64'(paddr), 64'(v.addr));
          chk("pwrite", 64'(pwrite), 64'(v.write));
          chk("pwdata", 64'(pwdata), 64'(v.wdata));
          chk("pstrb", 64'(pstrb), 64'(v.exp_strb));
          chk("pprot", 64'(pprot), 64'(v.prot));
          chk("req_ready_busy", 64'(req_ready), 64'd0);
        end
        if (penable === 1'b1) begin
          acc++;
          pready  = (acc == v.waits + 1);
          prdata  = pready ? v.prdata : $urandom;
          pslverr = pready ? v.slverr : 1'b1;
        end else begin
          // junk that must not be sampled outside ACCESS
          pready  = 1'($urandom_range(1));
          prdata  = $urandom;
          pslverr = 1'($urandom_range(1));
        end
        @(negedge clk);
        lat++;
      end
    end
    pready = 1'b0; pslverr = 1'b0; prdata = '0;
    chk("rsp_seen", 64'(seen), 64'd1);
    if (!seen) begin
      void'(sb_q.pop_front());
      do_reset();
      return;
    end
    chk("access_cycles", 64'(acc), 64'(v.exp_acc));
    chk("psel_cycles", 64'(sel), 64'(v.exp_acc + 1));
    chk("rsp_latency", 64'(lat), 64'(v.exp_acc + 2));
    held.rdata = rsp_rdata; held.err = rsp_err; held.to = rsp_timeout;
    for (int h = 0; h < v.hold; h++) begin
      req_valid = 1'b1;
      rsp_ready = 1'b0;
      @(negedge clk);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      chk("bp_psel", 64'(psel), 64'd0);
      chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_rdata_stable", 64'(rsp_rdata), 64'(held.rdata));
      chk("bp_err_stable", 64'({rsp_err, rsp_timeout}), 64'({held.err, held.to}));
    end
    if (sb_q.size() == 0) begin
      chk("sb_nonempty", 64'd0, 64'd1);
    end else begin
      got = sb_q.pop_front();
      chk("rsp_rdata", 64'(rsp_rdata), 64'(got.rdata));
      chk("rsp_err", 64'(rsp_err), 64'(got.err));
      chk("rsp_timeout", 64'(rsp_timeout), 64'(got.to));
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_after_hs", 64'(rsp_valid), 64'd0);
    chk("ready_after_hs", 64'(req_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = mk(1'b0, 32'h1000, 32'h0, 4'hF, PROT_DEFAULT, 0, 1'b0, 32'hDEADBEEF, 0,
                 32'hDEADBEEF, 1'b0, 1'b0, 1, 4'h0);
    vecs[1] = mk(1'b1, 32'h2004, 32'hA5A5A5A5, 4'b0101, PROT_PRIV, 3, 1'b0, 32'hFFFF0000, 0,
                 32'h0, 1'b0, 1'b0, 4, 4'b0101);
    vecs[2] = mk(1'b0, 32'h3000, 32'h0, 4'h0, PROT_DEFAULT, 0, 1'b1, 32'h0BAD0BAD, 0,
                 32'h0BAD0BAD, 1'b1, 1'b0, 1, 4'h0);
    vecs[3] = mk(1'b0, 32'h4000, 32'h0, 4'h0, PROT_DEFAULT, 99, 1'b0, 32'h55555555, 0,
                 32'h0, 1'b1, 1'b1, 4, 4'h0);
    vecs[4] = mk(1'b0, 32'h4004, 32'h0, 4'h0, PROT_DEFAULT, 3, 1'b0, 32'h12345678, 0,
                 32'h12345678, 1'b0, 1'b0, 4, 4'h0);
    vecs[5] = mk(1'b1, 32'h5000, 32'h11223344, 4'hF, PROT_PRIV, 1, 1'b1, 32'h99999999, 5,
                 32'h0, 1'b1, 1'b0, 2, 4'hF);
    vecs[6] = mk(1'b1, 32'h6000, 32'h0F0F0F0F, 4'h3, PROT_DEFAULT, 99, 1'b0, 32'h0, 0,
                 32'h0, 1'b1, 1'b1, 4, 4'h3);
    vecs[7] = mk(1'b0, 32'h7000, 32'h0, 4'hC, 3'b011, 2, 1'b0, 32'hCAFEF00D, 2,
                 32'hCAFEF00D, 1'b0, 1'b0, 3, 4'h0);

    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_wdata = '0;
    req_strb = '0; req_prot = '0; rsp_ready = 1'b0; pready = 1'b0; prdata = '0; pslverr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_psel", 64'(psel), 64'd0);
    chk("rst_penable", 64'(penable), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_fields", 64'({rsp_rdata, rsp_err, rsp_timeout}), 64'd0);
    chk("rst_apb_fields", 64'({paddr, pwrite, pstrb, pprot}), 64'd0);
    chk("rst_pwdata", 64'(pwdata), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 64'(req_ready), 64'd1);

    for (int i = 0; i < 8; i++) run_txn(vecs[i]);

    // reset while in ACCESS
    req_valid = 1'b1; req_addr = 32'h8000; req_write = 1'b0; req_strb = '0; req_prot = '0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_penable", 64'(penable), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midacc_rst_psel", 64'(psel), 64'd0);
    chk("midacc_rst_penable", 64'(penable), 64'd0);
    chk("midacc_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midacc_rst_req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_midacc_rst", 64'(req_ready), 64'd1);
    run_txn(vecs[4]);

    // reset while the response is waiting
    req_valid = 1'b1; req_addr = 32'h9000; req_write = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    pready = 1'b1; prdata = 32'h77777777;
    @(negedge clk);
    pready = 1'b0;
    @(negedge clk);
    chk("pre_rst_rsp_valid", 64'(rsp_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("resp_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_txn(vecs[0]);

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_apb_req_master
